// File: rtl/mest_pro_loader.sv
// Byte-stream program loader for MESTPro unified memory: takes a framed stream,
// assembles MSB-first instruction words, writes them from address 0 and launches the core.
module mest_pro_loader #(
  parameter int          INSTRUCTION_SIZE = 16,
  parameter int          ADDR_BITS        = 16,
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic [7:0]                  i_byte,
  input  logic                        i_byte_valid,
  output logic                        o_byte_ready,
  input  logic                        i_abort,
  output logic                        o_mm_select,
  output logic [ADDR_BITS-1:0]        o_mm_addr,
  output logic [INSTRUCTION_SIZE-1:0] o_mm_dat,
  output logic                        o_cs,
  output logic                        o_we,
  output logic                        o_start,
  output logic                        o_load_done,
  output logic                        o_load_error
);

  localparam int BYTES = INSTRUCTION_SIZE / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]                  r_state;
  logic [7:0]                  r_len_hi;
  logic [15:0]                 r_remaining;
  logic [ADDR_BITS-1:0]        r_addr;
  logic [INSTRUCTION_SIZE-1:0] r_word;
  logic [7:0]                  r_chk;
  logic [CNT_W-1:0]            r_byte_cnt;
  logic                        r_mm_select;
  logic                        r_write;
  logic                        r_start;
  logic                        r_done;
  logic                        r_error;

  logic                        w_ready;
  logic                        w_busy;
  logic                        w_abort;
  logic                        w_accept;
  logic [15:0]                 w_len;
  logic [INSTRUCTION_SIZE-1:0] w_word_shifted;

  assign w_ready  = (r_state != S_WRITE) && (r_state != S_DONE);
  assign w_busy   = (r_state != S_IDLE) && (r_state != S_DONE);
  // An abort takes priority over a byte offered in the same cycle, which is then dropped.
  assign w_abort  = i_abort && w_busy;
  assign w_accept = i_byte_valid && w_ready && !w_abort;
  assign w_len    = {r_len_hi, i_byte};

  generate
    if (BYTES == 1) begin : g_single_byte
      assign w_word_shifted = i_byte;
    end else begin : g_multi_byte
      assign w_word_shifted = {r_word[INSTRUCTION_SIZE-9:0], i_byte};
    end
  endgenerate

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_len_hi    <= '0;
      r_remaining <= '0;
      r_addr      <= '0;
      r_word      <= '0;
      r_chk       <= '0;
      r_byte_cnt  <= '0;
      r_mm_select <= 1'b0;
      r_write     <= 1'b0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_write <= 1'b0;
      if (w_abort) begin
        // A write already on the bus this cycle still lands; only the frame is dropped.
        r_state     <= S_IDLE;
        r_error     <= 1'b1;
        r_mm_select <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept && (i_byte == SYNC_BYTE)) begin
              r_state     <= S_LEN_HI;
              r_done      <= 1'b0;
              r_error     <= 1'b0;
              r_mm_select <= 1'b1;
              r_addr      <= '0;
              r_chk       <= '0;
              r_byte_cnt  <= '0;
            end
          end
          S_LEN_HI: begin
            if (w_accept) begin
              r_len_hi <= i_byte;
              r_state  <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (w_accept) begin
              r_remaining <= w_len;
              r_state     <= (w_len == 16'd0) ? S_CHECK : S_DATA;
            end
          end
          S_DATA: begin
            if (w_accept) begin
              r_word <= w_word_shifted;
              r_chk  <= r_chk ^ i_byte;
              if (r_byte_cnt == LAST_BYTE) begin
                r_byte_cnt <= '0;
                r_write    <= 1'b1;
                r_state    <= S_WRITE;
              end else begin
                r_byte_cnt <= r_byte_cnt + CNT_ONE;
              end
            end
          end
          S_WRITE: begin
            r_addr      <= r_addr + ADDR_ONE;
            r_remaining <= r_remaining - 16'd1;
            r_state     <= (r_remaining == 16'd1) ? S_CHECK : S_DATA;
          end
          S_CHECK: begin
            if (w_accept) begin
              r_mm_select <= 1'b0;
              if (i_byte == r_chk) begin
                r_state <= S_DONE;
                r_start <= 1'b1;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_error <= 1'b1;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state     <= S_IDLE;
            r_mm_select <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_byte_ready = w_ready;
  assign o_mm_select  = r_mm_select;
  assign o_mm_addr    = r_addr;
  assign o_mm_dat     = r_word;
  assign o_cs         = r_write;
  assign o_we         = r_write;
  assign o_start      = r_start;
  assign o_load_done  = r_done;
  assign o_load_error = r_error;

endmodule

// File: tb/tb_mest_pro_loader.sv
// Randomized frame stimulus for mest_pro_loader, checked each cycle against a
// queue-based model of the writes and start pulses a frame must produce.
module tb_mest_pro_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic [7:0]    i_byte = 8'h00;
  logic          i_byte_valid = 1'b0;
  logic          o_byte_ready;
  logic          i_abort = 1'b0;
  logic          o_mm_select;
  logic [AW-1:0] o_mm_addr;
  logic [15:0]   o_mm_dat;
  logic          o_cs;
  logic          o_we;
  logic          o_start;
  logic          o_load_done;
  logic          o_load_error;

  mest_pro_loader #(.INSTRUCTION_SIZE(16), .ADDR_BITS(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready), .i_abort(i_abort), .o_mm_select(o_mm_select),
    .o_mm_addr(o_mm_addr), .o_mm_dat(o_mm_dat), .o_cs(o_cs), .o_we(o_we),
    .o_start(o_start), .o_load_done(o_load_done), .o_load_error(o_load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_waddr_q[$];
  logic [15:0]   exp_wdata_q[$];
  int            exp_start = 0;
  logic          exp_done = 1'b0;
  logic          exp_err = 1'b0;
  logic [7:0]    stream[$];
  logic [15:0]   tb_mem [16];
  logic          prev_start = 1'b0;
  logic [AW-1:0] cmp_a;
  logic [15:0]   cmp_d;

  always @(posedge clk) if (o_cs && o_we) tb_mem[o_mm_addr] <= o_mm_dat;

  // Per-cycle comparison against the model queues.
  always @(negedge clk) begin
    if (i_reset_n) begin
      checks++;
      if (o_cs !== o_we) begin
        errors++; $display("FAIL cs_we: cs=%b we=%b required equal", o_cs, o_we);
      end
      if (o_cs) begin
        checks++;
        if (o_byte_ready !== 1'b0 || o_mm_select !== 1'b1) begin
          errors++; $display("FAIL write_ctrl: ready=%b select=%b required 0/1", o_byte_ready, o_mm_select);
        end
        checks++;
        if (exp_waddr_q.size() == 0) begin
          errors++; $display("FAIL unexpected_write: addr=%0h dat=%0h required no write", o_mm_addr, o_mm_dat);
        end else begin
          cmp_a = exp_waddr_q.pop_front();
          cmp_d = exp_wdata_q.pop_front();
          if (o_mm_addr !== cmp_a || o_mm_dat !== cmp_d) begin
            errors++;
            $display("FAIL write: got @%0h=%h required @%0h=%h", o_mm_addr, o_mm_dat, cmp_a, cmp_d);
          end
        end
      end
      if (o_start) begin
        checks++;
        if (exp_start == 0 || o_mm_select !== 1'b0 || o_load_done !== 1'b1 || o_byte_ready !== 1'b0 || prev_start) begin
          errors++;
          $display("FAIL start: pending=%0d select=%b done=%b ready=%b prev=%b required 1+/0/1/0/0",
                   exp_start, o_mm_select, o_load_done, o_byte_ready, prev_start);
        end
        if (exp_start > 0) exp_start--;
      end
      prev_start = o_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic exp_write(input int a, input logic [15:0] d);
    exp_waddr_q.push_back(AW'(a));
    exp_wdata_q.push_back(d);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    bit acc;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        i_byte_valid = 1'b0;
        i_byte = 8'($urandom);
        @(negedge clk);
      end
    end
    i_byte = b;
    i_byte_valid = 1'b1;
    n = 0;
    while (1) begin
      acc = o_byte_ready;
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 20) begin
        checks++; errors++;
        $display("FAIL byte_accept: byte %h not taken within 20 cycles, required acceptance", b);
        break;
      end
    end
  endtask

  task automatic send_stream(input bit gaps);
    foreach (stream[i]) send_byte(stream[i], gaps);
    i_byte_valid = 1'b0;
    stream.delete();
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    stream.push_back(b0); stream.push_back(b1); stream.push_back(b2); stream.push_back(b3);
  endtask

  // Random frame: garbage, SYNC, length, words, checksum (possibly corrupted).
  task automatic build_frame(input int n, input bit good, input int garbage);
    logic [7:0]  chk;
    logic [7:0]  g;
    logic [15:0] w;
    chk = 8'h00;
    for (int i = 0; i < garbage; i++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h3C;
      stream.push_back(g);
    end
    stream.push_back(8'hA5);
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n & 255));
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
      chk = chk ^ w[15:8] ^ w[7:0];
      exp_write(i % 16, w);
    end
    stream.push_back(good ? chk : (chk ^ 8'(1 << $urandom_range(0, 7))));
    if (good) exp_start++;
    exp_done = good;
    exp_err  = !good;
  endtask

  task automatic finish_frame(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_select"}, 32'(o_mm_select), 32'd0);
    check({tag, "_done"}, 32'(o_load_done), 32'(exp_done));
    check({tag, "_error"}, 32'(o_load_error), 32'(exp_err));
    check({tag, "_writes_left"}, 32'(exp_waddr_q.size()), 32'd0);
    check({tag, "_starts_left"}, 32'(exp_start), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_select", 32'(o_mm_select), 32'd0);
    check("reset_cs_we", 32'({o_cs, o_we, o_start}), 32'd0);
    check("reset_flags", 32'({o_load_done, o_load_error}), 32'd0);
    check("reset_addr_dat", 32'({o_mm_addr, o_mm_dat}), 32'd0);
    #2 i_reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(o_byte_ready), 32'd1);

    // Good frame
    push_bytes(8'hA5, 8'h00, 8'h02, 8'h12);
    push_bytes(8'h34, 8'h56, 8'h78, 8'h08);
    exp_write(0, 16'h1234); exp_write(1, 16'h5678);
    exp_start++; exp_done = 1'b1; exp_err = 1'b0;
    send_stream(1'b1);
    finish_frame("good");
    check("good_mem0", 32'(tb_mem[0]), 32'h1234);
    check("good_mem1", 32'(tb_mem[1]), 32'h5678);

    // Bad checksum: writes happen, no start
    push_bytes(8'hA5, 8'h00, 8'h02, 8'h12);
    push_bytes(8'h34, 8'h56, 8'h78, 8'h09);
    exp_write(0, 16'h1234); exp_write(1, 16'h5678);
    exp_done = 1'b0; exp_err = 1'b1;
    send_stream(1'b1);
    finish_frame("badchk");

    // Leading garbage, continuous valid
    push_bytes(8'h00, 8'hFF, 8'hA5, 8'h00);
    push_bytes(8'h01, 8'hAB, 8'hCD, 8'h66);
    exp_write(0, 16'hABCD);
    exp_start++; exp_done = 1'b1; exp_err = 1'b0;
    send_stream(1'b0);
    finish_frame("garbage");
    check("garbage_mem0", 32'(tb_mem[0]), 32'hABCD);

    // Empty frames
    push_bytes(8'hA5, 8'h00, 8'h00, 8'h00);
    exp_start++; exp_done = 1'b1; exp_err = 1'b0;
    send_stream(1'b1);
    finish_frame("empty_good");
    push_bytes(8'hA5, 8'h00, 8'h00, 8'h01);
    exp_done = 1'b0; exp_err = 1'b1;
    send_stream(1'b1);
    finish_frame("empty_bad");

    // Abort after the third data byte of a 2-word frame
    stream.push_back(8'hA5); stream.push_back(8'h00); stream.push_back(8'h02);
    stream.push_back(8'hC1); stream.push_back(8'hC2); stream.push_back(8'hC3);
    exp_write(0, 16'hC1C2);
    exp_done = 1'b0; exp_err = 1'b1;
    send_stream(1'b0);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    finish_frame("abort");

    // Address wrap: 20 words into a 16-entry address space
    build_frame(20, 1'b1, 0);
    send_stream(1'b0);
    finish_frame("wrap");

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      build_frame($urandom_range(0, 6), ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
      send_stream(bit'($urandom_range(0, 1)));
      finish_frame("rand");
    end

    // Reset in the middle of DATA
    stream.push_back(8'hA5); stream.push_back(8'h00); stream.push_back(8'h02); stream.push_back(8'h11);
    send_stream(1'b0);
    check("mid_select_before_reset", 32'(o_mm_select), 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    check("midrst_select", 32'(o_mm_select), 32'd0);
    check("midrst_addr_dat", 32'({o_mm_addr, o_mm_dat}), 32'd0);
    check("midrst_ctrl", 32'({o_cs, o_we, o_start, o_load_done, o_load_error}), 32'd0);
    exp_waddr_q.delete(); exp_wdata_q.delete(); exp_start = 0;
    @(negedge clk);
    #2 i_reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", 32'(o_byte_ready), 32'd1);
    build_frame(3, 1'b1, 1);
    send_stream(1'b1);
    finish_frame("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
